mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the consecutive lost fetch cycles before the fetch port takes priority.
REQ-002 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_req  in  1  fetch port read request.
REQ-005 SHALL have port i_addr  in  32  fetch byte address.
REQ-006 SHALL have port i_gnt  out  1  fetch request accepted this cycle.
REQ-007 SHALL have port i_rvalid  out  1  fetch read data valid on rdata.
REQ-008 SHALL have port d_req  in  1  data port request, load or store.
REQ-009 SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-010 SHALL have port d_addr  in  32  data byte address.
REQ-011 SHALL have port d_wmask  in  4  store byte enables.
REQ-012 SHALL have port d_wdata  in  32  store data, pre-aligned by the requester.
REQ-013 SHALL have port d_gnt  out  1  data request accepted this cycle.
REQ-014 SHALL have port d_rvalid  out  1  load data valid on rdata.
REQ-015 SHALL have port rdata  out  32  shared read return, qualified by i_rvalid or d_rvalid.
REQ-016 SHALL have port sram_en  out  1  SRAM access enable.
REQ-017 SHALL have port sram_we  out  1  SRAM write enable.
REQ-018 SHALL have port sram_addr  out  32  SRAM address.
REQ-019 SHALL have port sram_wmask  out  4  SRAM byte mask; 4'b0000 on reads.
REQ-020 SHALL have port sram_wdata  out  32  SRAM write data.
REQ-021 SHALL have port sram_rdata  in  32  SRAM read data, valid one cycle after a read enable.

Function
REQ-022 SHALL grant at most one port per cycle; gnt is combinational from req and state; acceptance = req & gnt.
REQ-023 SHALL drive sram_en/we/addr/wmask/wdata combinationally from the granted port in the acceptance cycle; with no grant, sram_en = 0 and sram_we = 0.
REQ-024 SHALL place fetch accesses as reads: sram_we = 0, sram_wmask = 0.
REQ-025 SHALL, when both ports request, grant d when starve_cnt < STARVE_LIMIT, otherwise grant i.
REQ-026 SHALL increment starve_cnt, saturating at STARVE_LIMIT, each cycle i_req = 1 and i_gnt = 0; it SHALL clear when i is granted or i_req = 0.
REQ-027 SHALL track the response owner with state IDLE, RSP_I and RSP_D; next state = RSP_I on an accepted fetch, RSP_D on an accepted load, otherwise IDLE (stores return no response).
REQ-028 SHALL, in RSP_I, assert i_rvalid = 1 and rdata = sram_rdata; in RSP_D, assert d_rvalid = 1 and rdata = sram_rdata; in IDLE, both rvalids = 0 and rdata = 0.
REQ-029 SHALL accept a new request in the same cycle a response is returned, giving a back-to-back throughput of one access per cycle.
REQ-030 SHALL require requesters to hold req and payload stable until granted; unaccepted requests are not latched.
REQ-031 SHALL give a store immediately followed by a load to the same address the new data (SRAM write-first ordering; no internal forwarding).

Reset
REQ-032 SHALL, while reset = 1, force i_gnt = d_gnt = 0, sram_en = sram_we = 0, both rvalids = 0, state = IDLE and starve_cnt = 0; a response pending at reset SHALL be dropped.
REQ-033 SHALL accept requests from the first cycle after reset deasserts.

Configuration
REQ-034 SHALL, with ARB_RR_EN defined, replace REQ-025/026 with round-robin arbitration: on a conflict, grant the port not granted last; last_winner resets to i, so d wins the first conflict after reset; starve_cnt is absent.
REQ-035 SHALL, without ARB_RR_EN, use fixed data priority with the starvation counter.

Structure
REQ-036 SHALL take the state enum (IDLE/RSP_I/RSP_D) and the port-id constants from defines.sv; the arbitration decision SHALL be the single sub-module mem_arb_pick (combinational winner select).

Verification
REQ-037 SHALL check: reset, then i_req with i_addr = 0x1C000000 -> i_gnt same cycle, i_rvalid next cycle with rdata = the SRAM word.
REQ-038 SHALL check: d store d_addr = 0x100, d_wmask = 4'b0010, d_wdata = 0x0000AB00, then a load of 0x100 -> d_rvalid with byte 1 = 0xAB.
REQ-039 SHALL check: i_req and d_req held continuously -> d granted cycles 0-3, i granted cycle 4, starve_cnt cleared (ARB_RR_EN off).
REQ-040 SHALL check: same stimulus with ARB_RR_EN on -> grants alternate d, i, d, i.
REQ-041 SHALL check: reset asserted the cycle after an accepted load -> d_rvalid stays 0 and sram_en = 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: response-owner states, port ids
// and helpers that build the SRAM command for each port.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RSP_I = 2'd1,
        RSP_D = 2'd2
    } rsp_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_e;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } sram_cmd_t;

    localparam sram_cmd_t SRAM_CMD_IDLE = '0;

    // Fetches are always plain reads.
    function automatic sram_cmd_t fetch_cmd(input logic [ADDR_W-1:0] addr);
        sram_cmd_t c;
        c      = SRAM_CMD_IDLE;
        c.en   = 1'b1;
        c.addr = addr;
        return c;
    endfunction

    // Loads present an all-zero mask so the SRAM never sees a stray byte enable.
    function automatic sram_cmd_t data_cmd(input logic              we,
                                           input logic [ADDR_W-1:0] addr,
                                           input logic [MASK_W-1:0] wmask,
                                           input logic [DATA_W-1:0] wdata);
        sram_cmd_t c;
        c      = SRAM_CMD_IDLE;
        c.en   = 1'b1;
        c.we   = we;
        c.addr = addr;
        if (we) begin
            c.wmask = wmask;
            c.wdata = wdata;
        end
        return c;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select between the fetch and data ports; i_prio decides
// who wins when both request, hold suppresses every grant.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic hold,
    input  logic i_req,
    input  logic d_req,
    input  logic i_prio,
    output logic i_gnt,
    output logic d_gnt
);

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!hold) begin
            if (i_req && d_req) begin
                i_gnt = i_prio;
                d_gnt = !i_prio;
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port SRAM with one-cycle read latency.
// Define ARB_RR_EN for round-robin arbitration instead of data priority with starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [MASK_W-1:0] d_wmask,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic i_prio;

    mem_arb_pick u_pick (
        .hold   (reset),
        .i_req  (i_req),
        .d_req  (d_req),
        .i_prio (i_prio),
        .i_gnt  (i_gnt),
        .d_gnt  (d_gnt)
    );

`ifdef ARB_RR_EN
    port_id_e last_winner;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= PORT_I;
        end else if (i_gnt) begin
            last_winner <= PORT_I;
        end else if (d_gnt) begin
            last_winner <= PORT_D;
        end
    end

    assign i_prio = (last_winner == PORT_D);
`else
    // Sized so STARVE_LIMIT itself is representable, even for tiny limits.
    localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (i_req && !i_gnt) begin
            starve_cnt <= (starve_cnt >= CNT_MAX) ? CNT_MAX : starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    assign i_prio = (starve_cnt >= CNT_MAX);
`endif

    sram_cmd_t cmd;

    always_comb begin
        cmd = SRAM_CMD_IDLE;
        if (i_gnt) begin
            cmd = fetch_cmd(i_addr);
        end else if (d_gnt) begin
            cmd = data_cmd(d_we, d_addr, d_wmask, d_wdata);
        end
    end

    assign sram_en    = cmd.en;
    assign sram_we    = cmd.we;
    assign sram_addr  = cmd.addr;
    assign sram_wmask = cmd.wmask;
    assign sram_wdata = cmd.wdata;

    rsp_state_e state;
    logic       i_rvalid_q;
    logic       d_rvalid_q;

    // Response owner for the read issued last cycle; stores leave it IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else if (i_gnt) begin
            state      <= RSP_I;
            i_rvalid_q <= 1'b1;
            d_rvalid_q <= 1'b0;
        end else if (d_gnt && !d_we) begin
            state      <= RSP_D;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b1;
        end else begin
            state      <= IDLE;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end
    end

    // Gating with reset drops a response that was pending when reset arrived.
    assign i_rvalid = i_rvalid_q && !reset;
    assign d_rvalid = d_rvalid_q && !reset;

    always_comb begin
        rdata = '0;
        if (!reset) begin
            case (state)
                RSP_I, RSP_D: rdata = sram_rdata;
                default:      rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an SRAM model and a read-response scoreboard.
// Define ARB_RR_EN to check the round-robin build.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] rdata;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [3:0]  sram_wmask;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    always begin
        clk = 1'b0;
        #5;
        clk = 1'b1;
        #5;
    end

    mem_port_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wmask    (d_wmask),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .rdata      (rdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM model: one-cycle read latency, byte-masked writes.
    logic [31:0]   sram_mem [1024];
    logic [1023:0] sram_wr;
    logic [31:0]   sram_rd_q;
    logic          mem_clr;

    assign sram_rdata = sram_rd_q;

    function automatic logic [31:0] sram_peek(input logic [31:0] a);
        return sram_wr[a[11:2]] ? sram_mem[a[11:2]] : init_word({a[31:2], 2'b00});
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            sram_wr   <= '0;
            sram_rd_q <= '0;
        end else if (sram_en) begin
            if (sram_we) begin
                sram_mem[sram_addr[11:2]] <= merge(sram_peek(sram_addr), sram_wdata, sram_wmask);
                sram_wr[sram_addr[11:2]]  <= 1'b1;
            end else begin
                sram_rd_q <= sram_peek(sram_addr);
            end
        end
    end

    // Reference memory contents as the bench believes them to be.
    logic [31:0] ref_mem [logic [29:0]];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word({a[31:2], 2'b00});
    endfunction

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] last_rdata;
    logic        last_dv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Every read response is due exactly one cycle after its acceptance.
    task automatic check_rsp(input string tag);
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_rvalid"}, 32'({i_rvalid, d_rvalid}), e.is_d ? 32'd1 : 32'd2);
            chk({tag, "_rdata"}, rdata, e.data);
        end else begin
            chk({tag, "_norsp"}, 32'({i_rvalid, d_rvalid}), 32'd0);
            chk({tag, "_rdata0"}, rdata, 32'd0);
        end
    endtask

    task automatic step(input string tag, input logic exp_i, input logic exp_d);
        exp_t e;
        @(negedge clk);
        check_rsp(tag);
        last_rdata = rdata;
        last_dv    = d_rvalid;
        chk({tag, "_i_gnt"}, 32'(i_gnt), 32'(exp_i));
        chk({tag, "_d_gnt"}, 32'(d_gnt), 32'(exp_d));
        chk({tag, "_sram_en"}, 32'(sram_en), 32'(exp_i | exp_d));
        if (exp_i) begin
            chk({tag, "_i_addr"}, sram_addr, i_addr);
            chk({tag, "_i_we"}, 32'(sram_we), 32'd0);
            chk({tag, "_i_mask"}, 32'(sram_wmask), 32'd0);
            e.is_d = 1'b0;
            e.data = ref_read(i_addr);
            sb_q.push_back(e);
        end else if (exp_d) begin
            chk({tag, "_d_addr"}, sram_addr, d_addr);
            chk({tag, "_d_we"}, 32'(sram_we), 32'(d_we));
            if (d_we) begin
                chk({tag, "_d_mask"}, 32'(sram_wmask), 32'(d_wmask));
                chk({tag, "_d_wdata"}, sram_wdata, d_wdata);
                ref_mem[d_addr[31:2]] = merge(ref_read(d_addr), d_wdata, d_wmask);
            end else begin
                chk({tag, "_d_mask"}, 32'(sram_wmask), 32'd0);
                e.is_d = 1'b1;
                e.data = ref_read(d_addr);
                sb_q.push_back(e);
            end
        end else begin
            chk({tag, "_we_idle"}, 32'(sram_we), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pat1;
    logic [4:0] pat2;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        last_rdata = '0;
        last_dv    = 1'b0;
        mem_clr    = 1'b1;
        reset      = 1'b1;
        i_req      = 1'b0;
        i_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wmask    = '0;
        d_wdata    = '0;
`ifdef ARB_RR_EN
        pat1 = 8'b0101_0101;
        pat2 = 5'b01010;
`else
        pat1 = 8'b1110_1111;
        pat2 = 5'b01111;
`endif
        @(posedge clk);
        #1;
        mem_clr = 1'b0;

        // Requests while reset is held must not be granted.
        i_req  = 1'b1;
        i_addr = 32'h1C00_0000;
        d_req  = 1'b1;
        d_addr = 32'h0000_0400;
        @(negedge clk);
        chk("rst_i_gnt", 32'(i_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        @(posedge clk);
        #1;

        // First cycle out of reset: fetch accepted, data returned next cycle.
        reset = 1'b0;
        d_req = 1'b0;
        step("fetch", 1'b1, 1'b0);
        i_req = 1'b0;
        step("fetch_rsp", 1'b0, 1'b0);

        // Byte store followed by a load of the same word.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0100;
        d_wmask = 4'b0010;
        d_wdata = 32'h0000_AB00;
        step("store", 1'b0, 1'b1);
        d_we    = 1'b0;
        d_wmask = 4'b0000;
        d_wdata = '0;
        step("load", 1'b0, 1'b1);
        d_req = 1'b0;
        step("load_rsp", 1'b0, 1'b0);
        chk("load_dvalid", 32'(last_dv), 32'd1);
        chk("load_byte1", 32'(last_rdata[15:8]), 32'h0000_00AB);

        // Reset in the cycle after an accepted load drops the response.
        d_req  = 1'b1;
        d_addr = 32'h0000_0300;
        step("ld_rst", 1'b0, 1'b1);
        d_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_drop_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_drop_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("rst_drop_sram_en", 32'(sram_en), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("after_rst", 1'b0, 1'b0);

        // Both ports requesting continuously; pat bit set = data port wins.
        i_req  = 1'b1;
        i_addr = 32'h1C00_0040;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0200;
        for (int c = 0; c < 8; c++) begin
            step($sformatf("arb%0d", c), !pat1[c], pat1[c]);
        end

        // Dropping i_req clears the starvation count before the next conflict.
        i_req = 1'b0;
        step("d_only", 1'b0, 1'b1);
        i_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step($sformatf("arb2_%0d", c), !pat2[c], pat2[c]);
        end

        i_req = 1'b0;
        d_req = 1'b0;
        step("drain", 1'b0, 1'b0);
        step("idle", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
